// File: rtl/rom_seq_reader.sv
// ---------------------------------------------------------------------------
// rom_seq_reader
//
// Address sequencer and output register wrapped around an asynchronous-read
// memory. Walks word addresses 0..ADDR_LENTH-1, registers each word read
// back from the memory and offers it downstream over a valid/ready
// handshake. An optional idle gap separates consecutive fetches, and the
// scan either stops after the last word or wraps back to address 0.
//
// Parameters
//   DATA_WIDTH  width of the memory address bus and of a data word
//   ADDR_LENTH  number of words scanned (1 .. 2**DATA_WIDTH)
//   GAP_CYCLES  idle cycles between consecutive fetches (0 = back-to-back)
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start      begin a scan at address 0 (only looked at while idle)
//   loop       at the last-word transfer: 1 = wrap to address 0, 0 = finish
//   abort      drop the scan and return to idle (wins over everything but rst)
//   rom_addr   registered address to the memory
//   rom_data   memory word, combinational function of rom_addr
//   out_data   registered word for the consumer
//   out_valid  out_data holds a word the consumer has not yet taken
//   out_ready  consumer takes the word when out_valid && out_ready at an edge
//   busy       high in every state except idle
//   done       one-cycle pulse when a non-looping scan completes
// ---------------------------------------------------------------------------
module rom_seq_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_LENTH = 16,
    parameter int GAP_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  loop,
    input  logic                  abort,
    output logic [DATA_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        st_idle,
        st_fetch,
        st_hold,
        st_gap,
        st_done
    } state_t;

    // The gap counter only ever holds GAP_CYCLES-1 down to 0.
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD =
        (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
    localparam logic [DATA_WIDTH-1:0] LAST_ADDR = DATA_WIDTH'(ADDR_LENTH - 1);

    state_t                  state,     state_nxt;
    logic [DATA_WIDTH-1:0]   addr_nxt;
    logic [DATA_WIDTH-1:0]   data_nxt;
    logic                    valid_nxt;
    logic [GAP_W-1:0]        gap_cnt,   gap_nxt;

    wire transfer = out_valid && out_ready;
    wire at_last  = (rom_addr == LAST_ADDR);

    // Next-state and next-register logic.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_nxt = state;
        addr_nxt  = rom_addr;
        data_nxt  = out_data;
        valid_nxt = out_valid;
        gap_nxt   = gap_cnt;

        if (abort && state != st_idle) begin
            // Abort beats a same-edge transfer: the word is dropped, and
            // out_data is left as it was.
            state_nxt = st_idle;
            addr_nxt  = '0;
            valid_nxt = 1'b0;
            gap_nxt   = '0;
        end else begin
            unique case (state)
                st_idle: begin
                    addr_nxt = '0;
                    if (start && !abort) begin
                        state_nxt = st_fetch;
                    end
                end
                st_fetch: begin
                    // rom_data has had the whole cycle to settle from rom_addr.
                    data_nxt  = rom_data;
                    valid_nxt = 1'b1;
                    state_nxt = st_hold;
                end
                st_hold: begin
                    if (transfer) begin
                        valid_nxt = 1'b0;
                        if (at_last && !loop) begin
                            state_nxt = st_done;
                        end else begin
                            addr_nxt = at_last ? '0 : rom_addr + 1'b1;
                            if (GAP_CYCLES > 0) begin
                                state_nxt = st_gap;
                                gap_nxt   = GAP_LOAD;
                            end else begin
                                state_nxt = st_fetch;
                            end
                        end
                    end
                end
                st_gap: begin
                    // Loaded with GAP_CYCLES-1 on entry, so leaving at zero
                    // gives exactly GAP_CYCLES cycles here.
                    if (gap_cnt == '0) begin
                        state_nxt = st_fetch;
                    end else begin
                        gap_nxt = gap_cnt - 1'b1;
                    end
                end
                st_done: begin
                    addr_nxt  = '0;
                    state_nxt = st_idle;
                end
                default: begin
                    state_nxt = st_idle;
                    addr_nxt  = '0;
                    valid_nxt = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers; rst overrides every other input.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all
        // registers update together from the values seen before the edge.
        if (rst) begin
            state     <= st_idle;
            rom_addr  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            gap_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            rom_addr  <= addr_nxt;
            out_data  <= data_nxt;
            out_valid <= valid_nxt;
            gap_cnt   <= gap_nxt;
        end
    end

    assign busy = (state != st_idle);
    assign done = (state == st_done);

endmodule

// File: tb/tb_rom_seq_reader.sv
// ---------------------------------------------------------------------------
// tb_rom_seq_reader
//
// Three instances share clk and the control inputs, each with its own memory
// model (word i = 8'hA0 + i):
//   u_base  16 words, no gap
//   u_gap   16 words, GAP_CYCLES = 3
//   u_one   1 word,  no gap
// Only one instance is examined in each phase; a reset starts every phase.
// Inputs change 1 time unit after a rising edge, outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_rom_seq_reader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic loop = 1'b0;
    logic abort = 1'b0;
    logic out_ready = 1'b0;

    logic [7:0] addr_b, data_b, rdata_b;
    logic       valid_b, busy_b, done_b;
    logic [7:0] addr_g, data_g, rdata_g;
    logic       valid_g, busy_g, done_g;
    logic [7:0] addr_o, data_o, rdata_o;
    logic       valid_o, busy_o, done_o;

    // Asynchronous-read memory models.
    assign rdata_b = 8'hA0 + addr_b;
    assign rdata_g = 8'hA0 + addr_g;
    assign rdata_o = 8'hA0 + addr_o;

    always #5 clk = ~clk;

    rom_seq_reader #(.DATA_WIDTH(8), .ADDR_LENTH(16), .GAP_CYCLES(0)) u_base (
        .clk(clk), .rst(rst), .start(start), .loop(loop), .abort(abort),
        .rom_addr(addr_b), .rom_data(rdata_b), .out_data(data_b),
        .out_valid(valid_b), .out_ready(out_ready), .busy(busy_b), .done(done_b)
    );

    rom_seq_reader #(.DATA_WIDTH(8), .ADDR_LENTH(16), .GAP_CYCLES(3)) u_gap (
        .clk(clk), .rst(rst), .start(start), .loop(loop), .abort(abort),
        .rom_addr(addr_g), .rom_data(rdata_g), .out_data(data_g),
        .out_valid(valid_g), .out_ready(out_ready), .busy(busy_g), .done(done_g)
    );

    rom_seq_reader #(.DATA_WIDTH(8), .ADDR_LENTH(1), .GAP_CYCLES(0)) u_one (
        .clk(clk), .rst(rst), .start(start), .loop(loop), .abort(abort),
        .rom_addr(addr_o), .rom_data(rdata_o), .out_data(data_o),
        .out_valid(valid_o), .out_ready(out_ready), .busy(busy_o), .done(done_o)
    );

    int errors = 0;
    int checks = 0;

    // ins = {rst, start, loop, abort, out_ready} applied before the edge;
    // addr/data/flg = {valid, busy, done} expected just after it.
    typedef struct packed {
        logic [4:0] ins;
        logic [7:0] addr;
        logic [7:0] data;
        logic [2:0] flg;
    } vec_t;

    vec_t vecs [28];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        // ---------------- table: reset, backpressure, abort ----------------
        vecs[0]  = {5'b11001, 8'h00, 8'h00, 3'b000}; // reset with start high
        vecs[1]  = {5'b11001, 8'h00, 8'h00, 3'b000};
        vecs[2]  = {5'b01001, 8'h00, 8'h00, 3'b010}; // start -> fetch
        vecs[3]  = {5'b00001, 8'h00, 8'hA0, 3'b110}; // word 0
        vecs[4]  = {5'b00001, 8'h01, 8'hA0, 3'b010};
        vecs[5]  = {5'b00001, 8'h01, 8'hA1, 3'b110};
        vecs[6]  = {5'b00001, 8'h02, 8'hA1, 3'b010};
        vecs[7]  = {5'b00001, 8'h02, 8'hA2, 3'b110};
        vecs[8]  = {5'b00001, 8'h03, 8'hA2, 3'b010};
        vecs[9]  = {5'b00001, 8'h03, 8'hA3, 3'b110}; // word 3 presented
        vecs[10] = {5'b00000, 8'h03, 8'hA3, 3'b110}; // 5 cycles of backpressure
        vecs[11] = {5'b01000, 8'h03, 8'hA3, 3'b110}; // start in hold ignored
        vecs[12] = {5'b01000, 8'h03, 8'hA3, 3'b110};
        vecs[13] = {5'b00000, 8'h03, 8'hA3, 3'b110};
        vecs[14] = {5'b00000, 8'h03, 8'hA3, 3'b110};
        vecs[15] = {5'b00001, 8'h04, 8'hA3, 3'b010}; // release
        vecs[16] = {5'b00001, 8'h04, 8'hA4, 3'b110};
        vecs[17] = {5'b00001, 8'h05, 8'hA4, 3'b010};
        vecs[18] = {5'b00001, 8'h05, 8'hA5, 3'b110};
        vecs[19] = {5'b00001, 8'h06, 8'hA5, 3'b010};
        vecs[20] = {5'b00001, 8'h06, 8'hA6, 3'b110};
        vecs[21] = {5'b00001, 8'h07, 8'hA6, 3'b010};
        vecs[22] = {5'b00001, 8'h07, 8'hA7, 3'b110}; // word 7 presented
        vecs[23] = {5'b01011, 8'h00, 8'hA7, 3'b000}; // abort beats transfer
        vecs[24] = {5'b01010, 8'h00, 8'hA7, 3'b000}; // start+abort in idle
        vecs[25] = {5'b01001, 8'h00, 8'hA7, 3'b010}; // fresh start
        vecs[26] = {5'b00001, 8'h00, 8'hA0, 3'b110}; // word 0 again
        vecs[27] = {5'b10001, 8'h00, 8'h00, 3'b000}; // reset beats transfer

        for (int i = 0; i < 28; i++) begin
            {rst, start, loop, abort, out_ready} = vecs[i].ins;
            tick();
            check($sformatf("vec%0d", i),
                  32'({addr_b, data_b, valid_b, busy_b, done_b}),
                  32'({vecs[i].addr, vecs[i].data, vecs[i].flg}));
        end

        // ---------------- full non-looping scan ----------------
        rst = 1'b0; start = 1'b1; loop = 1'b0; abort = 1'b0; out_ready = 1'b1;
        tick();
        start = 1'b0;
        check("scan_fetch", 32'(busy_b), 32'(1));
        for (int i = 0; i < 16; i++) begin
            tick();
            check($sformatf("scan_word%0d", i), 32'({addr_b, data_b, valid_b}),
                  32'({8'(i), 8'(8'hA0 + i), 1'b1}));
            tick();
            if (i < 15)
                check($sformatf("scan_step%0d", i), 32'({valid_b, done_b, addr_b}),
                      32'({1'b0, 1'b0, 8'(i + 1)}));
            else
                check("scan_done", 32'({valid_b, busy_b, done_b}), 32'(3'b011));
        end
        tick();
        check("scan_idle", 32'({busy_b, done_b, addr_b}), 32'(0));

        // ---------------- looping scan, loop dropped in pass two ----------------
        start = 1'b1; loop = 1'b1;
        tick();
        start = 1'b0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 16; i++) begin
                if (p == 1 && i == 5) loop = 1'b0;
                tick();
                check($sformatf("loop%0d_word%0d", p, i),
                      32'({addr_b, data_b, valid_b}),
                      32'({8'(i), 8'(8'hA0 + i), 1'b1}));
                tick();
                if (i == 15) begin
                    if (p == 0)
                        check("loop_wrap", 32'({done_b, addr_b, valid_b, busy_b}),
                              32'({1'b0, 8'h00, 1'b0, 1'b1}));
                    else
                        check("loop_done", 32'({done_b, busy_b}), 32'(2'b11));
                end
            end
        end
        tick();
        check("loop_idle", 32'({busy_b, done_b}), 32'(0));

        // ---------------- GAP_CYCLES = 3 ----------------
        rst = 1'b1; out_ready = 1'b0;
        tick();
        rst = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("gap_word0", 32'({addr_g, data_g, valid_g}), 32'({8'h00, 8'hA0, 1'b1}));
        out_ready = 1'b1;
        for (int w = 0; w < 3; w++) begin
            tick(); // transfer edge: valid falls
            check($sformatf("gap%0d_fall", w), 32'({valid_g, busy_g, addr_g}),
                  32'({1'b0, 1'b1, 8'(w + 1)}));
            for (int c = 1; c < 4; c++) begin
                tick();
                check($sformatf("gap%0d_idle%0d", w, c), 32'(valid_g), 32'(0));
            end
            tick();
            check($sformatf("gap%0d_next", w), 32'({data_g, valid_g}),
                  32'({8'(8'hA1 + w), 1'b1}));
        end
        tick(); // word 3 taken, now in gap
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("gap_abort", 32'({valid_g, busy_g, done_g, addr_g, data_g}),
              32'({1'b0, 1'b0, 1'b0, 8'h00, 8'hA3}));

        // ---------------- ADDR_LENTH = 1 ----------------
        rst = 1'b1; out_ready = 1'b0;
        tick();
        rst = 1'b0; start = 1'b1; loop = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("one_word_a", 32'({addr_o, data_o, valid_o}), 32'({8'h00, 8'hA0, 1'b1}));
        out_ready = 1'b1;
        tick();
        check("one_wrap", 32'({valid_o, done_o, busy_o, addr_o}),
              32'({1'b0, 1'b0, 1'b1, 8'h00}));
        tick();
        check("one_word_b", 32'({addr_o, data_o, valid_o}), 32'({8'h00, 8'hA0, 1'b1}));
        loop = 1'b0;
        tick();
        check("one_done", 32'({valid_o, busy_o, done_o}), 32'(3'b011));
        tick();
        check("one_idle", 32'({busy_o, done_o, addr_o}), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
